// File: rtl/gba_sound_fifo_if.sv
// Purpose : bundle of the CPU-write / direct_sound-pop signals and FIFO status
//           for one direct-sound channel FIFO.
// Ports   : master = MMIO writer plus direct_sound consumer; slave = the FIFO.
interface gba_sound_fifo_if #(
    parameter int SIZE_W = 3
);
    logic              wr_en;      // one-cycle MMIO write strobe
    logic              wr_half;    // 1 = 16-bit access
    logic              wr_hi;      // 16-bit access: 1 = upper halfword
    logic [31:0]       wr_data;
    logic              FIFO_re;    // pop strobe
    logic              FIFO_clr;   // flush strobe
    logic [SIZE_W-1:0] FIFO_size;  // saturated word count
    logic [31:0]       FIFO_val;   // head word, 0 when empty
    logic              full;
    logic              empty;
    logic              overflow;   // sticky dropped-push flag

    modport master (
        output wr_en, wr_half, wr_hi, wr_data, FIFO_re, FIFO_clr,
        input  FIFO_size, FIFO_val, full, empty, overflow
    );

    modport slave (
        input  wr_en, wr_half, wr_hi, wr_data, FIFO_re, FIFO_clr,
        output FIFO_size, FIFO_val, full, empty, overflow
    );
endinterface

// File: rtl/gba_sound_fifo.sv
// Purpose : direct-sound sample FIFO for one channel; 32-bit and paired
//           16-bit MMIO writes push words, direct_sound pops or flushes.
// Latency : a push is visible on FIFO_val the cycle after its write edge;
//           the head word is presented combinationally from registered state.
// Backpr. : none upstream; a push while full (without a same-cycle pop) is
//           dropped and raises the sticky overflow flag.
// Ports   : clock, reset (async, active-high), bus (slave side of
//           gba_sound_fifo_if: write strobes/data, pop/flush, status).
module gba_sound_fifo #(
    parameter int DEPTH  = 8,
    parameter int SIZE_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    gba_sound_fifo_if.slave        bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam int            SIZE_MAX = (1 << SIZE_W) - 1;

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic [15:0]       stage;
    logic              stage_valid;
    logic              overflow_q;

    logic              is_full;
    logic              is_empty;
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic [31:0]       push_word;
    logic [SIZE_W-1:0] size_sat;

    assign is_full  = (count == FULL_CNT);
    assign is_empty = (count == '0);

    // A low-halfword write only stages; 32-bit and high-halfword writes push.
    assign push_req = bus.wr_en & (~bus.wr_half | bus.wr_hi);
    assign pop      = bus.FIFO_re & ~is_empty;
    // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
    assign push_ok  = push_req & (~is_full | pop);

    // A high write with nothing staged pairs with a zero low half.
    assign push_word = bus.wr_half
                     ? {bus.wr_data[31:16], (stage_valid ? stage : 16'h0000)}
                     : bus.wr_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            stage       <= '0;
            stage_valid <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (bus.FIFO_clr) begin
            // Flush wins over any same-cycle push, pop or staging write.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            stage       <= '0;
            stage_valid <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (bus.wr_en) begin
                if (bus.wr_half && !bus.wr_hi) begin
                    stage       <= bus.wr_data[15:0];
                    stage_valid <= 1'b1;
                end else begin
                    stage_valid <= 1'b0;
                end
            end
        end
    end

    // Storage has no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clock) begin
        if (push_ok && !bus.FIFO_clr) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_comb begin
        size_sat = SIZE_W'(count);
        if (int'(count) > SIZE_MAX) begin
            size_sat = '1;
        end
    end

    assign bus.FIFO_size = size_sat;
    assign bus.FIFO_val  = is_empty ? 32'h0 : mem[rd_ptr];
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/gba_sound_fifo.md
Name: gba_sound_fifo

Overview:
- Direct-sound sample FIFO for one channel (A or B).
- Instantiated twice, upstream of the audio top-level.
- CPU-side MMIO writes to the FIFO_A/FIFO_B data registers (0x0A0/0x0A4) push 32-bit words.
- The direct_sound stage pops words via FIFO_re and flushes via FIFO_clr.
- Supports both word writes and halfword-pair writes, with halfword staging.

Parameters:
- DEPTH, 8, number of 32-bit words stored (GBA hardware: 32 bytes); must be a power of two, at least 2.
- SIZE_W, 3, width of the reported occupancy port; reported value saturates at 2^SIZE_W-1.

Ports:
- clock  input  1  system clock (gba_clk domain, shared with direct_sound)
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  MMIO write strobe to this channel's FIFO register, one cycle per access
- wr_half  input  1  1 = 16-bit access, 0 = 32-bit access
- wr_hi  input  1  for 16-bit accesses: 1 = upper halfword (addr+2), 0 = lower halfword
- wr_data  input  32  write data; a 16-bit access uses the lane selected by wr_hi
- FIFO_re  input  1  pop strobe from direct_sound
- FIFO_clr  input  1  flush strobe from direct_sound (SOUNDCNT_H reset bit)
- FIFO_size  output  SIZE_W  word count, saturated
- FIFO_val  output  32  head word; 0 when empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a push was dropped while full; cleared by reset or FIFO_clr

Behaviour:
- Storage: DEPTH x 32 registers, rd_ptr/wr_ptr of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset (async): pointers, count, staging register, staged-valid flag and overflow go to 0. Outputs after reset: FIFO_size=0, FIFO_val=0, full=0, empty=1, overflow=0. Storage contents are don't-care.
- Push source, 32-bit access: wr_en & ~wr_half pushes wr_data in that cycle. The staged-valid flag is cleared.
- Push source, low halfword: wr_en & wr_half & ~wr_hi loads wr_data[15:0] into the staging register and sets staged-valid. No push. A second low write overwrites the staging register.
- Push source, high halfword: wr_en & wr_half & wr_hi pushes {wr_data[31:16], staging} and clears staged-valid. If staged-valid was 0, it pushes {wr_data[31:16], 16'h0000}.
- Pop: FIFO_re with count>0 advances rd_ptr at the clock edge. FIFO_re while empty is ignored; no state change.
- Output timing:
  - FIFO_val = mem[rd_ptr] combinationally from registered state, so zero-latency head visibility.
  - The word pushed in cycle N is visible on FIFO_val in cycle N+1 if the FIFO was empty.
- Push while full: word dropped, overflow set to 1, pointers unchanged. A simultaneous pop in the same cycle frees a slot, so the push succeeds and overflow is not set.
- Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
- Simultaneous push and pop with count==0: pop ignored, push occurs, count becomes 1.
- FIFO_clr has highest priority. Pointers, count, staging, staged-valid and overflow all go to 0 at that edge. Any same-cycle push or pop is discarded.
- FIFO_size = count when count <= 2^SIZE_W-1, otherwise all ones. With the defaults, 8 words reads as 7; `full` disambiguates.
- All outputs other than FIFO_val are registered or derived from registered count only; no combinational path from wr_* or FIFO_* inputs to any output.

Test Plan:
- Reset then idle → FIFO_size=0, empty=1, FIFO_val=0, full=0, overflow=0.
- Word writes 0x11111111..0x88888888 (8 cycles) → full=1, FIFO_size=7. Eight FIFO_re pops return the values in order; empty=1 after the last pop.
- Halfword low 0xBEEF then high 0xDEAD0000 (wr_hi=1) → one push; FIFO_val=0xDEADBEEF, FIFO_size=1. A lone high write 0x12340000 with no prior low → pushes 0x12340000.
- Fill to 8, then a 9th word write → dropped, overflow=1, contents unchanged. Next cycle, write plus FIFO_re together → push accepted, count stays 8, overflow stays 1.
- Five words loaded, then FIFO_clr asserted in the same cycle as a word write and FIFO_re → count=0, empty=1, overflow=0; the written word is absent on the subsequent push/pop check.
- Wrap-around: push 6, pop 5, push 6, pop 7 → values emerge in exact push order across the pointer wrap. Assert reset mid-sequence (async, between edges) → outputs return to reset values immediately.
